cc_unit: RTL
============

Name: cc_unit

Overview:
- Holds the condition-code register (ZF, SF, OF) for the Y86-64 execute stage.
- Captures flags from the 64-bit add/sub/logic result when an OPq retires through execute.
- Evaluates the jXX/cmovXX condition (ifun 0–6) against the stored codes.
- Registers the resulting Cnd into the E→M pipeline slot, with stall and bubble control.
- It is the flag consumer of the ALU: the ALU produces over/sign/result, this block stores and interprets them.

Parameters:
- CC_RST, 3'b100, reset value of {ZF,SF,OF}; Y86 convention is ZF=1.
- W, 64, ALU result width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- set_cc  in  1  execute stage holds an OPq; capture flags this cycle
- kill_cc  in  1  exception present in M or W stage; suppress capture
- alu_res  in  W  full ALU result
- alu_over  in  1  ALU overflow flag
- e_ifun  in  4  condition function code of the instruction in E
- e_valid  in  1  E stage holds a real (non-bubble) instruction
- m_stall  in  1  hold the E→M register
- m_bubble  in  1  load a bubble into the E→M register
- cc_out  out  3  {ZF,SF,OF} currently stored
- e_cnd  out  1  combinational condition result for the instruction in E
- e_cond_err  out  1  e_ifun > 6 while e_valid
- m_cnd  out  1  registered Cnd presented to the M stage
- m_valid  out  1  registered validity of the M-stage slot

Behaviour:
- Reset (rst=1 at a rising edge) sets:
  - cc_out=CC_RST
  - m_cnd=0
  - m_valid=0
- Reset overrides every other input, including in the middle of a stall.
- CC update: at a rising edge with set_cc=1 and kill_cc=0, the register loads:
  - ZF=(alu_res==0)
  - SF=alu_res[W-1]
  - OF=alu_over
- When set_cc=0 or kill_cc=1, the CC register holds its value.
- kill_cc wins over set_cc.
- m_stall does not block a CC update; the instruction has already executed.
- e_cnd is combinational from the registered cc_out, i.e. the flags as they stand at the start of the cycle:
  - 0 always: 1
  - 1 le: (SF^OF)|ZF
  - 2 l: SF^OF
  - 3 e: ZF
  - 4 ne: ~ZF
  - 5 ge: ~(SF^OF)
  - 6 g: ~(SF^OF)&~ZF
  - 7–15: e_cnd=0 and e_cond_err=e_valid
- An OPq that writes CC in cycle n is visible to e_cnd in cycle n+1.
- No same-cycle bypass. Hazard logic upstream guarantees the ordering.
- E→M register, evaluated at each rising edge in this priority order:
  1. rst
  2. m_bubble → m_cnd=0, m_valid=0
  3. m_stall → hold
  4. otherwise → m_cnd=e_cnd & e_valid, m_valid=e_valid
- Simultaneous m_bubble and m_stall: bubble wins.
- Latency: flags are 1 cycle from set_cc to cc_out. Cnd is 1 cycle from E to m_cnd.
- Width rules:
  - Zero detect covers all W bits.
  - No arithmetic is done inside the block; overflow comes only from alu_over.

Decomposition:
- Shared package y86_pkg holds:
  - condition codes C_YES=0, C_LE=1, C_L=2, C_E=3, C_NE=4, C_GE=5, C_G=6
  - CC bit indices ZF=2, SF=1, OF=0
  - default CC_RST
- One natural sub-module, cond_eval: purely combinational, ifun+cc → cnd, err.
- cc_unit instantiates cond_eval and owns the CC register and the E→M register.

Test Plan:
- Reset then idle: rst high 1 cycle → cc_out=3'b100, m_valid=0. Then e_ifun=3, e_valid=1 → e_cnd=1, next cycle m_cnd=1.
- Overflow capture: set_cc=1, alu_res=64'h8000_0000_0000_0000, alu_over=1 → next cycle cc_out=3'b011. e_ifun=2 (l) → e_cnd=0. e_ifun=5 (ge) → e_cnd=1.
- Kill suppression: cc_out=3'b100; set_cc=1, kill_cc=1, alu_res=5 → cc_out stays 3'b100 for the following cycles.
- Stall/bubble: e_ifun=4, cc ZF=0 → e_cnd=1.
  - Assert m_stall 2 cycles while e_ifun changes to 3 → m_cnd holds its value.
  - Assert m_stall and m_bubble together → m_cnd=0, m_valid=0.
- Illegal ifun: e_ifun=9, e_valid=1 → e_cnd=0, e_cond_err=1. With e_valid=0 → e_cond_err=0.
- Back-to-back ordering: cycle n set_cc with alu_res=0; cycle n+1 e_ifun=3 → e_cnd=1. Then rst in the middle of a stall → m_valid=0, cc_out=3'b100.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: condition function codes, CC bit layout, reset flags.
package y86_pkg;

    // jXX / cmovXX condition function codes (ifun field)
    typedef enum logic [3:0] {
        C_YES = 4'd0,
        C_LE  = 4'd1,
        C_L   = 4'd2,
        C_E   = 4'd3,
        C_NE  = 4'd4,
        C_GE  = 4'd5,
        C_G   = 4'd6
    } cond_e;

    // Bit positions inside the {ZF,SF,OF} condition-code vector
    localparam int unsigned ZF = 2;
    localparam int unsigned SF = 1;
    localparam int unsigned OF = 0;

    // Architectural reset value of the flags: ZF set, SF/OF clear
    localparam logic [2:0] CC_RST_DEFAULT = 3'b100;

endpackage

// File: rtl/cond_eval.sv
// Combinational jXX/cmovXX condition evaluator: ifun + stored flags -> cnd, err.
module cond_eval
    import y86_pkg::*;
(
    input  logic [3:0] ifun,
    input  logic [2:0] cc,
    input  logic       valid,
    output logic       cnd,
    output logic       err
);

    logic zf;
    logic sf;
    logic of;
    logic lt;

    assign zf = cc[ZF];
    assign sf = cc[SF];
    assign of = cc[OF];
    assign lt = sf ^ of;

    // Decode the condition; undefined codes give cnd=0 and flag an error on real instructions
    always_comb begin
        cnd = 1'b0;
        err = 1'b0;
        case (ifun)
            C_YES:   cnd = 1'b1;
            C_LE:    cnd = lt | zf;
            C_L:     cnd = lt;
            C_E:     cnd = zf;
            C_NE:    cnd = ~zf;
            C_GE:    cnd = ~lt;
            C_G:     cnd = ~lt & ~zf;
            default: err = valid;
        endcase
    end

endmodule

// File: rtl/cc_unit.sv
// Y86-64 execute-stage condition-code register, condition evaluation and E->M Cnd slot.
module cc_unit
    import y86_pkg::*;
#(
    parameter logic [2:0]  CC_RST = CC_RST_DEFAULT,
    parameter int unsigned W      = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         set_cc,
    input  logic         kill_cc,
    input  logic [W-1:0] alu_res,
    input  logic         alu_over,
    input  logic [3:0]   e_ifun,
    input  logic         e_valid,
    input  logic         m_stall,
    input  logic         m_bubble,
    output logic [2:0]   cc_out,
    output logic         e_cnd,
    output logic         e_cond_err,
    output logic         m_cnd,
    output logic         m_valid
);

    logic [2:0] cc_q;

    assign cc_out = cc_q;

    // Condition evaluated against flags as registered at the start of the cycle (no bypass)
    cond_eval u_cond_eval (
        .ifun  (e_ifun),
        .cc    (cc_q),
        .valid (e_valid),
        .cnd   (e_cnd),
        .err   (e_cond_err)
    );

    // CC register: capture flags from a retiring OPq unless a later-stage exception kills it
    always_ff @(posedge clk) begin
        if (rst) begin
            cc_q <= CC_RST;
        end else if (set_cc && !kill_cc) begin
            cc_q[ZF] <= (alu_res == '0);
            cc_q[SF] <= alu_res[W-1];
            cc_q[OF] <= alu_over;
        end
    end

    // E->M slot: bubble beats stall; a bubble in E never carries a taken Cnd
    always_ff @(posedge clk) begin
        if (rst) begin
            m_cnd   <= 1'b0;
            m_valid <= 1'b0;
        end else if (m_bubble) begin
            m_cnd   <= 1'b0;
            m_valid <= 1'b0;
        end else if (!m_stall) begin
            m_cnd   <= e_cnd & e_valid;
            m_valid <= e_valid;
        end
    end

endmodule
